// File: rtl/pipeline_ctrl.sv
// Pipeline latch sequencer: per-cycle advance/hold/bubble decisions for PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB, plus halt drain, saturating stall counter and D-wait watchdog.
module pipeline_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DWAIT_LIMIT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_halt,
  input  logic             mem_redirect,
  input  logic             ex_dload,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_pass,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             dwait_err
);

  localparam int DW_W = $clog2(DWAIT_LIMIT + 1);
  localparam logic [DW_W-1:0] DW_LIM  = DW_W'(DWAIT_LIMIT);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWAIT_LIMIT - 1);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

  state_t          state, next_state;
  logic [DW_W-1:0] dwait_cnt;
  logic            dstall;
  logic            load_use;
  logic            running;

  assign dstall   = (mem_dren | mem_dwen) & ~dhit;
  assign load_use = ex_dload & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign running  = (state == RUN) | (state == DWAIT);

  // An enable and a flush are never both set: a flushed latch captures a bubble, not data.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    next_state  = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_pass  = 1'b0;

    if (RST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      next_state  = RUN;
    end else begin
      case (state)
        RUN, DWAIT: begin
          if (dstall) begin
            next_state = DWAIT;
          end else if (mem_halt) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_pass  = 1'b1;
            next_state  = DRAIN;
          end else begin
            next_state = RUN;
            memwb_pass = 1'b1;
            if (mem_redirect) begin
              pc_en       = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
            end else if (load_use) begin
              // IF/ID keeps its still-valid instruction even if the fetch also missed.
              idex_flush = 1'b1;
              exmem_en   = 1'b1;
            end else if (!ihit) begin
              ifid_flush = 1'b1;
              idex_en    = 1'b1;
              exmem_en   = 1'b1;
            end else begin
              pc_en    = 1'b1;
              ifid_en  = 1'b1;
              idex_en  = 1'b1;
              exmem_en = 1'b1;
            end
          end
        end
        DRAIN: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_pass  = 1'b1;
          next_state  = HALTED;
        end
        HALTED: next_state = HALTED;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state     <= RUN;
      halt      <= 1'b0;
      stall_cnt <= '0;
      dwait_cnt <= '0;
      dwait_err <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DRAIN) halt <= 1'b1;
      if (running && !pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      // Counter is held at zero in RUN, so it starts fresh on every DWAIT entry.
      if (state == RUN) begin
        dwait_cnt <= '0;
      end else if (state == DWAIT) begin
        if (dwait_cnt != DW_LIM) dwait_cnt <= dwait_cnt + 1'b1;
        if (dwait_cnt == DW_LAST) dwait_err <= 1'b1;
      end
    end
  end

endmodule
